hack_exec_ctrl: RTL and testbench

- Multi-cycle fetch/decode/execute controller for the Hack CPU datapath. It sits directly upstream of the ALU and drives its operands and six control bits.
- Consumes the ALU's out/zr/ng to write back A/D/M and resolve jumps.
- Owns the A, D and PC registers, plus ready/valid-style handshakes to instruction ROM and data memory.

---
 rtl/hack_defs.sv | 26 ++
 rtl/hack_jump_cond.sv | 15 +
 rtl/hack_exec_ctrl.sv | 120 ++++++++++++
 tb/tb_hack_exec_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hack_defs.sv
// Shared definitions for the Hack execution controller:
// FSM state encoding, instruction field positions, ALU control width.
package hack_defs;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    MREAD  = 3'd2,
    EXEC   = 3'd3,
    WRITE  = 3'd4
  } state_t;

  localparam int CBIT   = 15;
  localparam int ABIT   = 12;
  localparam int CTL_HI = 11;
  localparam int CTL_LO = 6;
  localparam int DEST_A = 5;
  localparam int DEST_D = 4;
  localparam int DEST_M = 3;
  localparam int J_LT   = 2;
  localparam int J_EQ   = 1;
  localparam int J_GT   = 0;

  localparam int CTL_W  = 6;

endpackage

// File: rtl/hack_jump_cond.sv
// Hack jump condition: take = jump bits j[2:0] matched against ALU zr/ng.
// Ports: j (jump field), zr, ng (ALU flags) -> take.
module hack_jump_cond (
  input  logic [2:0] j,
  input  logic       zr,
  input  logic       ng,
  output logic       take
);
  import hack_defs::*;

  assign take = (j[J_LT] & ng)
              | (j[J_EQ] & zr)
              | (j[J_GT] & ~ng & ~zr);

endmodule

// File: rtl/hack_exec_ctrl.sv
// Multi-cycle fetch/decode/execute controller for the Hack CPU.
// Ports: clk/reset; ROM fetch (pc, instr_req/valid, instruction);
// data memory (mem_addr, mem_rd/valid/rdata, mem_we/wack/wdata);
// ALU drive (alu_x, alu_y, alu_ctl) and result (alu_out, zr, ng); retire.
module hack_exec_ctrl
  import hack_defs::*;
#(
  parameter int ADDR_W = 15,
  parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] pc,
  output logic              instr_req,
  input  logic              instr_valid,
  input  logic [15:0]       instruction,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic              mem_rd_valid,
  input  logic [15:0]       mem_rdata,
  output logic              mem_we,
  input  logic              mem_wack,
  output logic [15:0]       mem_wdata,
  output logic [15:0]       alu_x,
  output logic [15:0]       alu_y,
  output logic [CTL_W-1:0]  alu_ctl,
  input  logic [15:0]       alu_out,
  input  logic              alu_zr,
  input  logic              alu_ng,
  output logic              retire
);

  state_t            state;
  logic [15:0]       a;
  logic [15:0]       d;
  logic [15:0]       ir;
  logic [15:0]       m;
  logic [15:0]       res;
  logic [ADDR_W-1:0] waddr;
  logic [ADDR_W-1:0] a_addr;
  logic [ADDR_W-1:0] pc_inc;
  logic              take;

  assign a_addr = a[ADDR_W-1:0];
  assign pc_inc = pc + ADDR_W'(1);

  hack_jump_cond u_jmp (
    .j    (ir[J_LT:J_GT]),
    .zr   (alu_zr),
    .ng   (alu_ng),
    .take (take)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FETCH;
      pc    <= PC_RESET;
      a     <= '0;
      d     <= '0;
      ir    <= '0;
      m     <= '0;
      res   <= '0;
      waddr <= '0;
    end else begin
      unique case (state)
        FETCH: begin
          if (instr_valid) begin
            ir    <= instruction;
            state <= DECODE;
          end
        end
        DECODE: begin
          if (!ir[CBIT]) begin
            a     <= {1'b0, ir[14:0]};
            pc    <= pc_inc;
            state <= FETCH;
          end else begin
            state <= ir[ABIT] ? MREAD : EXEC;
          end
        end
        MREAD: begin
          if (mem_rd_valid) begin
            m     <= mem_rdata;
            state <= EXEC;
          end
        end
        EXEC: begin
          // old A feeds both the write address and the jump target
          res   <= alu_out;
          waddr <= a_addr;
          if (ir[DEST_A]) a <= alu_out;
          if (ir[DEST_D]) d <= alu_out;
          pc    <= take ? a_addr : pc_inc;
          state <= ir[DEST_M] ? WRITE : FETCH;
        end
        WRITE: begin
          if (mem_wack) state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

  // requests are gated by reset so an in-flight handshake drops at once
  assign instr_req = ~reset & (state == FETCH);
  assign mem_rd    = ~reset & (state == MREAD);
  assign mem_we    = ~reset & (state == WRITE);

  assign retire = ~reset & (
      ((state == DECODE) & ~ir[CBIT])
    | ((state == EXEC)   & ~ir[DEST_M])
    | ((state == WRITE)  & mem_wack));

  assign mem_addr  = (state == WRITE) ? waddr : a_addr;
  assign mem_wdata = res;
  assign alu_x     = d;
  assign alu_y     = ir[ABIT] ? m : a;
  assign alu_ctl   = ir[CTL_HI:CTL_LO];

endmodule

// File: tb/tb_hack_exec_ctrl.sv
// Self-checking bench for hack_exec_ctrl: table of small programs
// plus hand sequences for memory stalls and reset during a write.
module tb_hack_exec_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [14:0] pc;
  logic        instr_req;
  logic        instr_valid;
  logic [15:0] instruction;
  logic [14:0] mem_addr;
  logic        mem_rd;
  logic        mem_rd_valid;
  logic [15:0] mem_rdata;
  logic        mem_we;
  logic        mem_wack;
  logic [15:0] mem_wdata;
  logic [15:0] alu_x;
  logic [15:0] alu_y;
  logic [5:0]  alu_ctl;
  logic [15:0] alu_out;
  logic        alu_zr;
  logic        alu_ng;
  logic        retire;

  logic [15:0] rom [4];
  logic [15:0] rd_data = 16'h0;
  int          fetch_max = 0;
  int          rd_lat = 0;
  int          we_lat = 0;

  int          fetched;
  int          rd_cnt;
  int          we_cnt;
  int          wr_cnt;
  logic [14:0] wr_addr;
  logic [15:0] wr_data;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hack_exec_ctrl #(.ADDR_W(15), .PC_RESET(15'h0)) dut (
    .clk          (clk),
    .reset        (reset),
    .pc           (pc),
    .instr_req    (instr_req),
    .instr_valid  (instr_valid),
    .instruction  (instruction),
    .mem_addr     (mem_addr),
    .mem_rd       (mem_rd),
    .mem_rd_valid (mem_rd_valid),
    .mem_rdata    (mem_rdata),
    .mem_we       (mem_we),
    .mem_wack     (mem_wack),
    .mem_wdata    (mem_wdata),
    .alu_x        (alu_x),
    .alu_y        (alu_y),
    .alu_ctl      (alu_ctl),
    .alu_out      (alu_out),
    .alu_zr       (alu_zr),
    .alu_ng       (alu_ng),
    .retire       (retire)
  );

  function automatic logic [15:0] alu_f(
    input logic [15:0] x0, input logic [15:0] y0, input logic [5:0] c);
    logic [15:0] x, y, o;
    x = c[5] ? 16'h0 : x0;
    x = c[4] ? ~x : x;
    y = c[3] ? 16'h0 : y0;
    y = c[2] ? ~y : y;
    o = c[1] ? (x + y) : (x & y);
    o = c[0] ? ~o : o;
    return o;
  endfunction

  assign alu_out = alu_f(alu_x, alu_y, alu_ctl);
  assign alu_zr  = (alu_out == 16'h0);
  assign alu_ng  = alu_out[15];

  assign instruction  = rom[pc[1:0]];
  assign instr_valid  = instr_req && (fetched < fetch_max);
  assign mem_rdata    = rd_data;
  assign mem_rd_valid = mem_rd && (rd_cnt >= rd_lat);
  assign mem_wack     = mem_we && (we_cnt >= we_lat);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetched <= 0;
      rd_cnt  <= 0;
      we_cnt  <= 0;
      wr_cnt  <= 0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      if (instr_valid) fetched <= fetched + 1;
      rd_cnt <= (mem_rd && !mem_rd_valid) ? rd_cnt + 1 : 0;
      we_cnt <= (mem_we && !mem_wack) ? we_cnt + 1 : 0;
      if (mem_we && mem_wack) begin
        wr_cnt  <= wr_cnt + 1;
        wr_addr <= mem_addr;
        wr_data <= mem_wdata;
      end
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic [63:0] prog;
    int          n;
    logic [15:0] rdata;
    int          first;
    int          last;
    logic [15:0] pc;
    logic [15:0] a;
    logic [15:0] d;
    int          nwr;
    logic [15:0] waddr;
    logic [15:0] wdata;
  } vec_t;

  function automatic vec_t mk(
    input logic [15:0] p0, input logic [15:0] p1,
    input logic [15:0] p2, input logic [15:0] p3,
    input int n, input logic [15:0] rdata,
    input int first, input int last,
    input logic [15:0] epc, input logic [15:0] ea,
    input logic [15:0] ed, input int nwr,
    input logic [15:0] wa, input logic [15:0] wd);
    vec_t v;
    v.prog  = {p3, p2, p1, p0};
    v.n     = n;
    v.rdata = rdata;
    v.first = first;
    v.last  = last;
    v.pc    = epc;
    v.a     = ea;
    v.d     = ed;
    v.nwr   = nwr;
    v.waddr = wa;
    v.wdata = wd;
    return v;
  endfunction

  task automatic start_prog(input logic [63:0] p, input int n,
                            input logic [15:0] rd,
                            input int rl, input int wl);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) rom[i] = p[i*16 +: 16];
    fetch_max = n;
    rd_data   = rd;
    rd_lat    = rl;
    we_lat    = wl;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int cyc, rets, first, last;
    string s;
    start_prog(v.prog, v.n, v.rdata, 0, 0);
    cyc = 0; rets = 0; first = 0; last = 0;
    while (rets < v.n && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (retire) begin
        rets++;
        if (rets == 1) first = cyc;
        last = cyc;
      end
    end
    s = $sformatf("v%0d", idx);
    chk({s, "_retires"}, rets, v.n);
    @(negedge clk);
    chk({s, "_first_retire"}, first, v.first);
    chk({s, "_last_retire"}, last, v.last);
    chk({s, "_pc"}, {17'h0, pc}, {16'h0, v.pc});
    chk({s, "_A"}, {17'h0, mem_addr}, {16'h0, v.a});
    chk({s, "_D"}, {16'h0, alu_x}, {16'h0, v.d});
    chk({s, "_nwr"}, wr_cnt, v.nwr);
    if (v.nwr != 0) begin
      chk({s, "_waddr"}, {17'h0, wr_addr}, {16'h0, v.waddr});
      chk({s, "_wdata"}, {16'h0, wr_data}, {16'h0, v.wdata});
    end
  endtask

  vec_t vt [10];

  initial begin
    int t;
    for (int i = 0; i < 4; i++) rom[i] = 16'h0;

    vt[0] = mk(16'h0005, 16'hEC10, 16'h0, 16'h0, 2, 16'h0,
               2, 5, 16'd2, 16'd5, 16'd5, 0, 16'h0, 16'h0);
    vt[1] = mk(16'd7, 16'hEC10, 16'd100, 16'hE7C8, 4, 16'h0,
               2, 11, 16'd4, 16'd100, 16'd7, 1, 16'd100, 16'd8);
    vt[2] = mk(16'hEE90, 16'h0040, 16'hE304, 16'h0, 3, 16'h0,
               3, 8, 16'h40, 16'h40, 16'hFFFF, 0, 16'h0, 16'h0);
    vt[3] = mk(16'hEA90, 16'h0040, 16'hE304, 16'h0, 3, 16'h0,
               3, 8, 16'd3, 16'h40, 16'h0, 0, 16'h0, 16'h0);
    vt[4] = mk(16'hEA90, 16'h0040, 16'hE302, 16'h0, 3, 16'h0,
               3, 8, 16'h40, 16'h40, 16'h0, 0, 16'h0, 16'h0);
    vt[5] = mk(16'd20, 16'hFDE8, 16'h0, 16'h0, 2, 16'd9,
               2, 7, 16'd2, 16'd10, 16'h0, 1, 16'd20, 16'd10);
    vt[6] = mk(16'd7, 16'hEC10, 16'd9, 16'hE301, 4, 16'h0,
               2, 10, 16'd9, 16'd9, 16'd7, 0, 16'h0, 16'h0);
    vt[7] = mk(16'h0030, 16'hEDE7, 16'h0, 16'h0, 2, 16'h0,
               2, 5, 16'h30, 16'h31, 16'h0, 0, 16'h0, 16'h0);
    vt[8] = mk(16'd6, 16'h8C10, 16'h0, 16'h0, 2, 16'h0,
               2, 5, 16'd2, 16'd6, 16'd6, 0, 16'h0, 16'h0);
    vt[9] = mk(16'h7FFF, 16'hEA87, 16'h0, 16'hEC10, 3, 16'h0,
               2, 8, 16'h0, 16'h7FFF, 16'h7FFF, 0, 16'h0, 16'h0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_instr_req", instr_req, 0);
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_retire", retire, 0);
    chk("rst_pc", {17'h0, pc}, 0);
    chk("rst_A", {17'h0, mem_addr}, 0);
    chk("rst_D", {16'h0, alu_x}, 0);
    chk("rst_ctl", {26'h0, alu_ctl}, 0);

    for (int i = 0; i < 10; i++) run_vec(vt[i], i);

    // write held while mem_wack stays low for three cycles
    start_prog(vt[1].prog, 4, 16'h0, 0, 3);
    t = 0;
    while (!mem_we && t < 40) begin @(negedge clk); t++; end
    chk("ws_we_seen", mem_we, 1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("ws_we_%0d", k), mem_we, 1);
      chk($sformatf("ws_addr_%0d", k), {17'h0, mem_addr}, 100);
      chk($sformatf("ws_wdata_%0d", k), {16'h0, mem_wdata}, 8);
      chk($sformatf("ws_retire_%0d", k), retire, (k == 3) ? 1 : 0);
      @(negedge clk);
    end
    chk("ws_we_drop", mem_we, 0);
    chk("ws_nwr", wr_cnt, 1);

    // read data arrives two cycles late
    start_prog(vt[5].prog, 2, 16'd9, 2, 0);
    t = 0;
    while (!mem_rd && t < 40) begin @(negedge clk); t++; end
    chk("rs_rd_seen", mem_rd, 1);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rs_rd_%0d", k), mem_rd, 1);
      chk($sformatf("rs_addr_%0d", k), {17'h0, mem_addr}, 20);
      @(negedge clk);
    end
    chk("rs_exec_rd", mem_rd, 0);
    chk("rs_exec_y", {16'h0, alu_y}, 9);
    chk("rs_exec_ctl", {26'h0, alu_ctl}, 32'h37);
    chk("rs_exec_retire", retire, 0);
    @(negedge clk);
    chk("rs_wr_we", mem_we, 1);
    chk("rs_wr_addr", {17'h0, mem_addr}, 20);
    chk("rs_wr_data", {16'h0, mem_wdata}, 10);
    chk("rs_wr_retire", retire, 1);

    // reset while a write waits for its ack
    start_prog(vt[1].prog, 4, 16'h0, 0, 1000);
    t = 0;
    while (!mem_we && t < 40) begin @(negedge clk); t++; end
    chk("rw_we_seen", mem_we, 1);
    reset = 1'b1;
    #1;
    chk("rw_we_drop", mem_we, 0);
    chk("rw_req", instr_req, 0);
    chk("rw_retire", retire, 0);
    chk("rw_pc", {17'h0, pc}, 0);
    chk("rw_A", {17'h0, mem_addr}, 0);
    chk("rw_D", {16'h0, alu_x}, 0);
    fetch_max = 1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rw_fetch_req", instr_req, 1);
    chk("rw_fetch_pc", {17'h0, pc}, 0);
    @(negedge clk);
    chk("rw_a_retire", retire, 1);
    @(negedge clk);
    chk("rw_A_after", {17'h0, mem_addr}, 7);
    chk("rw_nwr", wr_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
